div_rem_unit: RTL and testbench
===============================

DIV_REM_UNIT -- requirements
Module: div_rem_unit

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width; the iteration count equals XLEN.
REQ-002 SHALL have one clock and an asynchronous active-low reset:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low.
REQ-003 SHALL have the following ports:
- acc_in_A  input  XLEN  dividend.
- acc_in_B  input  XLEN  divisor.
- div_rem_order  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- div_rem_order_active  input  1  request valid; held until result consumed.
- stall  input  1  pipeline hold; the result is not consumed while high.
- flush  input  1  abort the current request.
- div_rem_ready  output  1  result valid this cycle.
- div_rem_result  output  XLEN  quotient or remainder.
- div_rem_busy  output  1  high in any non-IDLE state.

Function
REQ-004 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-005 In IDLE with div_rem_order_active=1 at cycle N, SHALL latch the operands, the op, and the operand signs (signed ops only), store absolute values, clear the counter, and enter CALC.
REQ-006 SHALL run CALC for exactly XLEN cycles (N+1..N+XLEN), performing one restoring shift-subtract step per cycle; the counter counts 0..XLEN-1 with no wrap.
REQ-007 SHALL spend one FIX cycle (N+XLEN+1) negating the quotient when the signs differ and the remainder when the dividend is negative, then register the result.
REQ-008 SHALL enter DONE at N+XLEN+2; div_rem_ready SHALL equal (state==DONE), with div_rem_result registered and stable throughout DONE.
REQ-009 In DONE, SHALL stay while stall=1 and go to IDLE on the first cycle with stall=0. That cycle is the consume cycle; a new request SHALL be accepted no earlier than the next cycle.
REQ-010 For divisor=0, SHALL go IDLE→DONE directly with ready at N+1: quotient all-ones, remainder = dividend.
REQ-011 For a signed op with dividend=0x80000000 and divisor=0xFFFFFFFF, SHALL go IDLE→DONE with ready at N+1: quotient 0x80000000, remainder 0.
REQ-012 SHALL ignore request inputs outside IDLE; operand changes mid-operation do not affect the result.
REQ-013 flush=1 in any state SHALL force IDLE next cycle with ready low, discarding the operation; flush has priority over a simultaneous request.
REQ-014 div_rem_ready SHALL never be high outside DONE and SHALL never rise without a preceding accepted request.

Reset
REQ-015 On reset low, SHALL immediately set state IDLE, div_rem_ready=0, div_rem_result=0, div_rem_busy=0, counter=0, and all internal registers 0, including mid-CALC.
REQ-016 After reset release, SHALL accept a request in the first cycle.

Configuration
REQ-017 With DIVREM_REUSE_EN defined, SHALL keep the last completed operands, signedness, quotient and remainder with a valid bit (cleared only by reset).
REQ-018 Under DIVREM_REUSE_EN, a request whose operands and signedness match the stored entry SHALL go IDLE→DONE with ready at N+1, returning the stored quotient or remainder per the op.
REQ-019 Under DIVREM_REUSE_EN, a flushed or aborted operation SHALL NOT update the stored entry.
REQ-020 Without DIVREM_REUSE_EN, SHALL instantiate no reuse storage and give every non-special request the full N+XLEN+2 latency.

Structure
REQ-021 Package divrem_pkg SHALL hold the state enum, the op encodings (OP_DIV, OP_DIVU, OP_REM, OP_REMU), and the XLEN default constant.
REQ-022 The single restoring iteration (partial remainder, quotient bit) SHALL be sub-module divrem_step, instantiated once.

Verification
REQ-023 DIV 100,7 accepted at cycle N → ready at N+34, result 14; REM 100,7 → 2.
REQ-024 DIV 0xFFFFFFF9 (-7),2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 0xFFFFFFF9,2 → 0x7FFFFFFC.
REQ-025 DIVU 0x12345678,0 → 0xFFFFFFFF at N+1; REMU → 0x12345678; DIV 0x80000000,0xFFFFFFFF → 0x80000000 at N+1; REM → 0.
REQ-026 flush at N+10 → IDLE at N+11, ready never asserted; then DIVU 10,3 → 3 at N'+34.
REQ-027 Reaching DONE with stall=1 for 5 cycles → ready high and result constant for 6 cycles; IDLE after stall falls.
REQ-028 With DIVREM_REUSE_EN: DIV 100,7 then REM 100,7 → 2 at N+1; without the macro → 2 at N+34.

Source files
------------

// File: rtl/divrem_pkg.sv
// divrem_pkg: shared constants for the iterative divide/remainder unit.
// Holds the FSM state encodings, the operation encodings and the default width.
package divrem_pkg;

   // Default operand/result width; the iteration count equals this width.
   localparam int unsigned XLEN_DEFAULT = 32;

   // FSM state encoding (plain constants so legacy tools can read them).
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_CALC = 2'd1;
   localparam state_t ST_FIX  = 2'd2;
   localparam state_t ST_DONE = 2'd3;

   // Operation encoding: bit 1 selects remainder, bit 0 selects unsigned.
   typedef logic [1:0] op_t;
   localparam op_t OP_DIV  = 2'b00;
   localparam op_t OP_DIVU = 2'b01;
   localparam op_t OP_REM  = 2'b10;
   localparam op_t OP_REMU = 2'b11;

   // True for DIV and REM.
   function automatic logic op_is_signed(input op_t op);
      return ~op[0];
   endfunction

   // True for REM and REMU.
   function automatic logic op_is_rem(input op_t op);
      return op[1];
   endfunction

endpackage

// File: rtl/divrem_step.sv
// divrem_step: one restoring division iteration.
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor when it fits, producing the new partial remainder and quotient bit.
module divrem_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] rem_in,
   input  logic            dvd_bit,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_out,
   output logic            q_bit
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   // Trial subtraction one bit wider than the operands; the top bit is the borrow.
   always_comb begin
      shifted = {rem_in, dvd_bit};
      diff    = shifted - {1'b0, divisor};
      q_bit   = ~diff[XLEN];
      rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
   end

endmodule

// File: rtl/div_rem_unit.sv
// div_rem_unit: iterative restoring divider for DIV/DIVU/REM/REMU.
// IDLE -> CALC (XLEN steps) -> FIX (sign correction) -> DONE (held while stall).
// Divide-by-zero and signed overflow complete straight from IDLE to DONE.
// Optional macro DIVREM_REUSE_EN keeps the last computed operation so a
// matching request (same operands and signedness) completes in one cycle.
module div_rem_unit
   import divrem_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] acc_in_A,
   input  logic [XLEN-1:0] acc_in_B,
   input  logic [1:0]      div_rem_order,
   input  logic            div_rem_order_active,
   input  logic            stall,
   input  logic            flush,
   output logic            div_rem_ready,
   output logic [XLEN-1:0] div_rem_result,
   output logic            div_rem_busy
);

   localparam int unsigned     CW       = $clog2(XLEN);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] ONE      = XLEN'(1);
   localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   // Architectural state.
   state_t          state_q,   state_d;
   logic [CW-1:0]   cnt_q,     cnt_d;
   logic [XLEN-1:0] dvd_q,     dvd_d;     // dividend shifting out, quotient shifting in
   logic [XLEN-1:0] dsr_q,     dsr_d;     // absolute divisor
   logic [XLEN-1:0] rem_q,     rem_d;     // partial remainder
   logic            rem_sel_q, rem_sel_d; // result is the remainder
   logic            qneg_q,    qneg_d;    // quotient needs negation
   logic            rneg_q,    rneg_d;    // remainder needs negation
   logic [XLEN-1:0] result_q,  result_d;

   // Request decode.
   logic            req_signed;
   logic            req_rem;
   logic            a_neg;
   logic            b_neg;
   logic            div_zero;
   logic            ovf;
   logic [XLEN-1:0] abs_a;
   logic [XLEN-1:0] abs_b;

   // Datapath.
   logic [XLEN-1:0] step_rem;
   logic            step_q;
   logic [XLEN-1:0] quo_fix;
   logic [XLEN-1:0] rem_fix;

`ifdef DIVREM_REUSE_EN
   logic            c_valid_q, c_valid_d;
   logic            c_sgn_q,   c_sgn_d;
   logic [XLEN-1:0] c_a_q,     c_a_d;
   logic [XLEN-1:0] c_b_q,     c_b_d;
   logic [XLEN-1:0] c_quo_q,   c_quo_d;
   logic [XLEN-1:0] c_rem_q,   c_rem_d;
   logic            sgn_q,     sgn_d;     // signedness of the operation in flight
   logic [XLEN-1:0] org_a_q,   org_a_d;   // original operands of the operation in flight
   logic [XLEN-1:0] org_b_q,   org_b_d;
   logic            hit;
`endif

   // Decode the incoming request: signedness, absolute operands, special cases.
   always_comb begin
      req_signed = op_is_signed(div_rem_order);
      req_rem    = op_is_rem(div_rem_order);
      a_neg      = req_signed & acc_in_A[XLEN-1];
      b_neg      = req_signed & acc_in_B[XLEN-1];
      abs_a      = a_neg ? (~acc_in_A + ONE) : acc_in_A;
      abs_b      = b_neg ? (~acc_in_B + ONE) : acc_in_B;
      div_zero   = (acc_in_B == '0);
      ovf        = req_signed & (acc_in_A == INT_MIN) & (acc_in_B == '1);
   end

   divrem_step #(
      .XLEN (XLEN)
   ) u_step (
      .rem_in  (rem_q),
      .dvd_bit (dvd_q[XLEN-1]),
      .divisor (dsr_q),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   // Sign correction applied in FIX: the remainder follows the dividend's sign.
   always_comb begin
      quo_fix = qneg_q ? (~dvd_q + ONE) : dvd_q;
      rem_fix = rneg_q ? (~rem_q + ONE) : rem_q;
   end

`ifdef DIVREM_REUSE_EN
   // A stored entry matches on both operands and signedness; the op picks the field.
   always_comb begin
      hit = c_valid_q & (acc_in_A == c_a_q) & (acc_in_B == c_b_q) & (req_signed == c_sgn_q);
   end
`endif

   // Next-state and datapath control; flush overrides everything.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dvd_d     = dvd_q;
      dsr_d     = dsr_q;
      rem_d     = rem_q;
      rem_sel_d = rem_sel_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      result_d  = result_q;
`ifdef DIVREM_REUSE_EN
      sgn_d     = sgn_q;
      org_a_d   = org_a_q;
      org_b_d   = org_b_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (div_rem_order_active && !flush) begin
               rem_sel_d = req_rem;
               if (div_zero) begin
                  result_d = req_rem ? acc_in_A : '1;
                  state_d  = ST_DONE;
               end else if (ovf) begin
                  result_d = req_rem ? '0 : INT_MIN;
                  state_d  = ST_DONE;
`ifdef DIVREM_REUSE_EN
               end else if (hit) begin
                  result_d = req_rem ? c_rem_q : c_quo_q;
                  state_d  = ST_DONE;
`endif
               end else begin
                  dvd_d   = abs_a;
                  dsr_d   = abs_b;
                  rem_d   = '0;
                  cnt_d   = '0;
                  qneg_d  = a_neg ^ b_neg;
                  rneg_d  = a_neg;
`ifdef DIVREM_REUSE_EN
                  sgn_d   = req_signed;
                  org_a_d = acc_in_A;
                  org_b_d = acc_in_B;
`endif
                  state_d = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            dvd_d = {dvd_q[XLEN-2:0], step_q};
            rem_d = step_rem;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_FIX;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_FIX: begin
            result_d = rem_sel_q ? rem_fix : quo_fix;
            state_d  = ST_DONE;
         end
         default: begin
            if (!stall) begin
               state_d = ST_IDLE;
            end
         end
      endcase
      if (flush) begin
         state_d = ST_IDLE;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         dvd_q     <= '0;
         dsr_q     <= '0;
         rem_q     <= '0;
         rem_sel_q <= 1'b0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dvd_q     <= dvd_d;
         dsr_q     <= dsr_d;
         rem_q     <= rem_d;
         rem_sel_q <= rem_sel_d;
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
         result_q  <= result_d;
      end
   end

`ifdef DIVREM_REUSE_EN
   // Store an entry only when a computed operation completes FIX without a flush.
   always_comb begin
      c_valid_d = c_valid_q;
      c_sgn_d   = c_sgn_q;
      c_a_d     = c_a_q;
      c_b_d     = c_b_q;
      c_quo_d   = c_quo_q;
      c_rem_d   = c_rem_q;
      if (state_q == ST_FIX && !flush) begin
         c_valid_d = 1'b1;
         c_sgn_d   = sgn_q;
         c_a_d     = org_a_q;
         c_b_d     = org_b_q;
         c_quo_d   = quo_fix;
         c_rem_d   = rem_fix;
      end
   end

   // Reuse storage registers; only reset clears the valid bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         c_valid_q <= 1'b0;
         c_sgn_q   <= 1'b0;
         c_a_q     <= '0;
         c_b_q     <= '0;
         c_quo_q   <= '0;
         c_rem_q   <= '0;
         sgn_q     <= 1'b0;
         org_a_q   <= '0;
         org_b_q   <= '0;
      end else begin
         c_valid_q <= c_valid_d;
         c_sgn_q   <= c_sgn_d;
         c_a_q     <= c_a_d;
         c_b_q     <= c_b_d;
         c_quo_q   <= c_quo_d;
         c_rem_q   <= c_rem_d;
         sgn_q     <= sgn_d;
         org_a_q   <= org_a_d;
         org_b_q   <= org_b_d;
      end
   end
`endif

   assign div_rem_ready  = (state_q == ST_DONE);
   assign div_rem_busy   = (state_q != ST_IDLE);
   assign div_rem_result = result_q;

endmodule

// File: tb/tb_div_rem_unit.sv
// tb_div_rem_unit: directed and randomized checks of div_rem_unit against an
// arithmetic reference model (plain SystemVerilog / and %, plus special cases).
module tb_div_rem_unit;
   import divrem_pkg::*;

   localparam int W = 32;
   localparam logic [W-1:0] MIN_S = 32'h8000_0000;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] acc_in_A;
   logic [W-1:0] acc_in_B;
   logic [1:0]   div_rem_order;
   logic         div_rem_order_active;
   logic         stall;
   logic         flush;
   logic         div_rem_ready;
   logic [W-1:0] div_rem_result;
   logic         div_rem_busy;

   div_rem_unit #(.XLEN(W)) dut (
      .clk                  (clk),
      .reset                (reset),
      .acc_in_A             (acc_in_A),
      .acc_in_B             (acc_in_B),
      .div_rem_order        (div_rem_order),
      .div_rem_order_active (div_rem_order_active),
      .stall                (stall),
      .flush                (flush),
      .div_rem_ready        (div_rem_ready),
      .div_rem_result       (div_rem_result),
      .div_rem_busy         (div_rem_busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model reuse entry: last fully computed operation.
   bit           m_valid = 1'b0;
   bit           m_sgn;
   logic [W-1:0] m_a, m_b;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Architectural result of the four ops, including the defined special cases.
   function automatic void ref_calc(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                    output logic [W-1:0] q, output logic [W-1:0] r, output bit special);
      logic signed [W-1:0] sx, sy;
      bit sgn;
      sx  = x;
      sy  = y;
      sgn = (op == OP_DIV) || (op == OP_REM);
      special = 1'b0;
      if (y == 0) begin
         q = '1; r = x; special = 1'b1;
      end else if (sgn && x == MIN_S && y == '1) begin
         q = MIN_S; r = '0; special = 1'b1;
      end else if (sgn) begin
         q = sx / sy; r = sx % sy;
      end else begin
         q = x / y; r = x % y;
      end
   endfunction

   // One complete transaction: request, wait for ready, hold for stall_n cycles, consume.
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int stall_n, input bit scramble);
      logic [W-1:0] q, r, exp;
      bit special, hit, sgn;
      int lat, exp_lat;
      bit seen;
      ref_calc(op, x, y, q, r, special);
      exp = op[1] ? r : q;
      sgn = (op == OP_DIV) || (op == OP_REM);
      hit = 1'b0;
`ifdef DIVREM_REUSE_EN
      hit = !special && m_valid && m_a == x && m_b == y && m_sgn == sgn;
`endif
      exp_lat = (special || hit) ? 1 : W + 2;
      div_rem_order        = op;
      acc_in_A             = x;
      acc_in_B             = y;
      div_rem_order_active = 1'b1;
      stall                = (stall_n > 0);
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (lat == 1) begin
            check_eq("busy_after_accept", div_rem_busy, 1);
            if (scramble) begin
               acc_in_A      = $urandom;
               acc_in_B      = $urandom;
               div_rem_order = 2'($urandom_range(0, 3));
            end
         end
         if (div_rem_ready) seen = 1'b1;
      end
      check_eq("latency", lat, exp_lat);
      check_eq("result", div_rem_result, exp);
      for (int i = 1; i <= stall_n; i++) begin
         @(posedge clk);
         #1 stall = (i < stall_n);
         @(negedge clk);
         check_eq("stall_ready", div_rem_ready, 1);
         check_eq("stall_result", div_rem_result, exp);
      end
      @(posedge clk);
      #1 div_rem_order_active = 1'b0;
      stall = 1'b0;
      @(negedge clk);
      check_eq("consumed_ready", div_rem_ready, 0);
      check_eq("consumed_busy", div_rem_busy, 0);
      if (!special) begin
         m_valid = 1'b1; m_a = x; m_b = y; m_sgn = sgn;
      end
      $display("txn op=%0d a=0x%08h b=0x%08h result=0x%08h exp=0x%08h lat=%0d", op, x, y,
               div_rem_result, exp, lat);
   endtask

   initial begin
      logic [W-1:0] ra, rb, last_a, last_b;
      logic [1:0]   rop;
      bit           ready_seen;
      int           pick;

      reset = 1'b1;
      acc_in_A = '0; acc_in_B = '0; div_rem_order = OP_DIV;
      div_rem_order_active = 1'b0; stall = 1'b0; flush = 1'b0;
      #1 reset = 1'b0;
      #1;
      check_eq("reset_ready", div_rem_ready, 0);
      check_eq("reset_busy", div_rem_busy, 0);
      check_eq("reset_result", div_rem_result, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Directed arithmetic cases.
      run_op(OP_DIV,  32'd100, 32'd7, 0, 1'b0);
      run_op(OP_REM,  32'd100, 32'd7, 0, 1'b0);
      run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 0, 1'b1);
      run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 0, 1'b1);
      run_op(OP_DIVU, 32'hFFFF_FFF9, 32'd2, 0, 1'b1);
      run_op(OP_DIVU, 32'h1234_5678, 32'd0, 0, 1'b0);
      run_op(OP_REMU, 32'h1234_5678, 32'd0, 0, 1'b0);
      run_op(OP_DIV,  MIN_S, 32'hFFFF_FFFF, 0, 1'b0);
      run_op(OP_REM,  MIN_S, 32'hFFFF_FFFF, 0, 1'b0);
      run_op(OP_DIVU, MIN_S, 32'hFFFF_FFFF, 0, 1'b0);

      // Result held through five stall cycles.
      run_op(OP_DIVU, 32'd1000, 32'd9, 5, 1'b0);

      // Flush in the middle of CALC: no ready, back to IDLE, no stored entry.
      div_rem_order = OP_DIVU; acc_in_A = 32'd10; acc_in_B = 32'd3;
      div_rem_order_active = 1'b1;
      ready_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (div_rem_ready) ready_seen = 1'b1;
      end
      flush = 1'b1;
      div_rem_order_active = 1'b0;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check_eq("flush_busy", div_rem_busy, 0);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (div_rem_ready) ready_seen = 1'b1;
      end
      check_eq("flush_no_ready", ready_seen, 0);
      run_op(OP_DIVU, 32'd10, 32'd3, 0, 1'b0);

      // Randomized mix, with occasional special operands and repeated operands.
      last_a = 32'd10; last_b = 32'd3;
      for (int n = 0; n < 40; n++) begin
         rop  = 2'($urandom_range(0, 3));
         pick = $urandom_range(0, 9);
         ra   = $urandom;
         rb   = $urandom;
         case (pick)
            0: rb = '0;
            1: begin ra = MIN_S; rb = '1; end
            2, 3: begin ra = last_a; rb = last_b; end
            4: rb = 32'($urandom_range(1, 20));
            5: rb = -32'($urandom_range(1, 20));
            default: ;
         endcase
         run_op(rop, ra, rb, $urandom_range(0, 2), 1'b1);
         last_a = ra; last_b = rb;
      end

      // Reset in the middle of CALC clears everything, including the stored entry.
      run_op(OP_DIV, 32'd100, 32'd7, 0, 1'b0);
      div_rem_order = OP_DIV; acc_in_A = 32'd5000; acc_in_B = 32'd3;
      div_rem_order_active = 1'b1;
      repeat (6) @(posedge clk);
      #1 reset = 1'b0;
      div_rem_order_active = 1'b0;
      #1;
      check_eq("midcalc_reset_busy", div_rem_busy, 0);
      check_eq("midcalc_reset_ready", div_rem_ready, 0);
      check_eq("midcalc_reset_result", div_rem_result, 0);
      m_valid = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      run_op(OP_REM, 32'd100, 32'd7, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
